// File: rtl/tmds_8b10b_encoder.sv
// -----------------------------------------------------------------------------
// tmds_8b10b_encoder
//
// Single-channel DVI/HDMI TMDS encoder. In a video period (VDE=1) each 8-bit
// byte becomes a transition-minimised, DC-balanced 10-bit symbol. In a control
// period (VDE=0) one of four fixed control symbols is sent. One symbol is
// produced every pixel clock, registered, with exactly one cycle of latency.
// The symbol feeds a 10:1 serializer that sends bit 0 first.
//
// Ports:
//   clk    in   1   pixel clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   VD     in   8   video data byte
//   CD     in   2   control data, used only while VDE=0
//   VDE    in   1   1 = encode VD, 0 = send control symbol for CD
//   TMDS   out 10   registered encoded symbol
//
// There is no handshake: the block accepts one input set and emits one
// symbol on every clock, unconditionally.
// -----------------------------------------------------------------------------
module tmds_8b10b_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] VD,
  input  logic [1:0] CD,
  input  logic       VDE,
  output logic [9:0] TMDS
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Running disparity (ones minus zeros) of the symbols sent in the
  // current video run. Cleared by every control cycle.
  logic signed [4:0] cnt;

  logic [3:0]        n1_vd;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic [3:0]        n1_q;
  logic signed [5:0] d_q;       // n1q - n0q
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_sum;
  logic              cnt_zero;
  logic              cnt_pos;
  logic              cnt_neg;
  logic              balanced;
  logic [9:0]        video_sym;
  logic signed [4:0] cnt_next;
  logic [9:0]        ctrl_sym;

  // Stage 1: transition minimisation.
  always_comb begin
    n1_vd = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1_vd = n1_vd + {3'b000, VD[i]};
    end
    use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !VD[0]);
    q_m      = 9'd0;
    q_m[0]   = VD[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ VD[i]) : (q_m[i-1] ^ VD[i]);
    end
    q_m[8] = ~use_xnor;
  end

  // Stage 2: DC balance against the running disparity.
  always_comb begin
    n1_q = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1_q = n1_q + {3'b000, q_m[i]};
    end
    // 2*n1q - 8 equals n1q - n0q.
    d_q      = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    cnt_ext  = {cnt[4], cnt};
    cnt_zero = (cnt == 5'sd0);
    cnt_neg  = cnt[4];
    cnt_pos  = !cnt_zero && !cnt_neg;
    balanced = (n1_q == 4'd4);

    if (cnt_zero || balanced) begin
      video_sym = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      cnt_sum   = q_m[8] ? (cnt_ext + d_q) : (cnt_ext - d_q);
    end else if ((cnt_pos && (n1_q > 4'd4)) || (cnt_neg && (n1_q < 4'd4))) begin
      // Current disparity would grow: send inverted data.
      video_sym = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_sum   = cnt_ext + (q_m[8] ? 6'sd2 : 6'sd0) - d_q;
    end else begin
      video_sym = {1'b0, q_m[8], q_m[7:0]};
      cnt_sum   = cnt_ext + d_q - (q_m[8] ? 6'sd0 : 6'sd2);
    end
    // Disparity is bounded to -16..+15 for legal sequences, so 5 bits hold it.
    cnt_next = cnt_sum[4:0];
  end

  always_comb begin
    case (CD)
      2'b00:   ctrl_sym = CTRL_00;
      2'b01:   ctrl_sym = CTRL_01;
      2'b10:   ctrl_sym = CTRL_10;
      default: ctrl_sym = CTRL_11;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TMDS <= CTRL_00;
      cnt  <= 5'sd0;
    end else if (VDE) begin
      TMDS <= video_sym;
      cnt  <= cnt_next;
    end else begin
      TMDS <= ctrl_sym;
      cnt  <= 5'sd0;
    end
  end

endmodule

// File: tb/tb_tmds_8b10b_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_8b10b_encoder
//
// Directed bench for the TMDS encoder. Expected symbols below were worked out
// by hand from the encoding rules; the running-disparity value reached after
// each step is noted beside it. A random tail decodes every video symbol back
// to its byte, checks control symbols against the code table and bounds the
// symbol-level running disparity of each video run.
// -----------------------------------------------------------------------------
module tb_tmds_8b10b_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic [9:0] tmds;

  int compared   = 0;
  int mismatched = 0;

  tmds_8b10b_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .VD    (vd),
    .CD    (cd),
    .VDE   (vde),
    .TMDS  (tmds)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checks
  task automatic check10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    compared++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Driver: drive inputs at the falling edge, check the symbol just after
  // the next rising edge.
  task automatic step(input logic [7:0] v, input logic [1:0] c, input logic e,
                      input logic [9:0] exp, input string tag);
    @(negedge clk);
    vd  = v;
    cd  = c;
    vde = e;
    @(posedge clk);
    #1;
    check10(tag, tmds, exp);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] r;
    d    = s[9] ? ~s[7:0] : s[7:0];
    r    = 8'd0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] t [4];
    t[0] = 10'b1101010100;
    t[1] = 10'b0010101011;
    t[2] = 10'b0101010100;
    t[3] = 10'b1010101011;
    return t[c];
  endfunction

  logic [7:0] prev_vd;
  logic [1:0] prev_cd;
  logic       prev_vde;
  int         run_disp;

  initial begin
    rst_n = 1'b0;
    vd    = 8'h00;
    cd    = 2'b00;
    vde   = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vd  = 8'($urandom_range(0, 255));
      cd  = 2'($urandom_range(0, 3));
      vde = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check10("reset_hold", tmds, 10'b1101010100);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vde   = 1'b0;
    cd    = 2'b00;

    // Control codes
    step(8'h00, 2'b00, 1'b0, 10'b1101010100, "ctrl_00");
    step(8'h00, 2'b01, 1'b0, 10'b0010101011, "ctrl_01");
    step(8'h00, 2'b10, 1'b0, 10'b0101010100, "ctrl_10");
    step(8'h00, 2'b11, 1'b0, 10'b1010101011, "ctrl_11");

    // Zero bytes from cnt=0
    step(8'h00, 2'b00, 1'b1, 10'b0100000000, "zero_1");   // cnt -8
    step(8'h00, 2'b00, 1'b1, 10'b1111111111, "zero_2");   // cnt +2

    // All-ones byte from cnt=0
    step(8'h00, 2'b00, 1'b0, 10'b1101010100, "ctrl_a");
    step(8'hFF, 2'b00, 1'b1, 10'b1000000000, "ones_1");   // cnt -8

    // Control cycle clears cnt
    step(8'h00, 2'b00, 1'b0, 10'b1101010100, "ctrl_b");
    step(8'h00, 2'b00, 1'b1, 10'b0100000000, "zero_after_ctrl"); // cnt -8

    // Mixed sequence covering all three balance cases
    step(8'h00, 2'b00, 1'b0, 10'b1101010100, "ctrl_c");
    step(8'h01, 2'b00, 1'b1, 10'b0111111111, "b01_a");    // A, cnt +8
    step(8'h01, 2'b00, 1'b1, 10'b1100000000, "b01_b");    // B, cnt +2
    step(8'h55, 2'b00, 1'b1, 10'b0100110011, "b55_bal");  // A balanced, cnt +2
    step(8'h03, 2'b00, 1'b1, 10'b0100000001, "b03_c");    // C, cnt -4
    step(8'h03, 2'b00, 1'b1, 10'b1111111110, "b03_b");    // B, cnt +4
    step(8'hFF, 2'b00, 1'b1, 10'b1000000000, "bff_b");    // B, cnt -4
    step(8'hFF, 2'b00, 1'b1, 10'b0011111111, "bff_c");    // C, cnt +2

    // Asynchronous reset between edges, then check cnt was cleared:
    // 0x01 gives 0111111111 from cnt=0 but 1100000000 from cnt=+2.
    #2;
    rst_n = 1'b0;
    #1;
    check10("async_reset", tmds, 10'b1101010100);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 2'b00, 1'b1, 10'b0111111111, "cnt_after_reset");

    // Random tail
    step(8'h00, 2'b00, 1'b0, 10'b1101010100, "ctrl_d");
    run_disp = 0;
    @(negedge clk);
    prev_vd  = 8'($urandom_range(0, 255));
    prev_cd  = 2'($urandom_range(0, 3));
    prev_vde = ($urandom_range(0, 9) < 7);
    vd  = prev_vd;
    cd  = prev_cd;
    vde = prev_vde;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk);
      #1;
      if (prev_vde) begin
        check8("soak_decode", decode(tmds), prev_vd);
        run_disp = run_disp + 2 * $countones(tmds) - 10;
        check_range("soak_disparity", run_disp, -16, 16);
      end else begin
        check10("soak_ctrl", tmds, ctrl_code(prev_cd));
        run_disp = 0;
      end
      @(negedge clk);
      prev_vd  = 8'($urandom_range(0, 255));
      prev_cd  = 2'($urandom_range(0, 3));
      prev_vde = ($urandom_range(0, 9) < 7);
      vd  = prev_vd;
      cd  = prev_cd;
      vde = prev_vde;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tmds_8b10b_encoder.md
Name: tmds_8b10b_encoder

Overview:
- Single-channel DVI/HDMI TMDS encoder: 8-bit video byte or 2-bit control code in, one registered 10-bit symbol per pixel clock out.
- One instance per colour channel (red, green, blue) in the HDMI transmit path; blue carries {vsync, hsync} on its control input.
- Output feeds a 10:1 serializer that sends bit 0 first.

Parameters:
- None.

Ports:
- clk  input  1  pixel clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- VD  input  8  video data byte.
- CD  input  2  control data; used only when VDE=0.
- VDE  input  1  video data enable: 1 selects video encoding, 0 selects control symbols.
- TMDS  output  10  encoded symbol, registered.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - While rst_n=0: TMDS=10'b1101010100 (control code for CD=00); disparity counter cnt=0.
- Latency: exactly 1 clk. Inputs sampled on edge k appear on TMDS after edge k. No handshake; one symbol every cycle.
- Stage 1, transition minimisation (combinational):
  - N1 = number of ones in VD.
  - use_xnor = (N1>4) or (N1==4 and VD[0]==0).
  - q_m[0] = VD[0].
  - q_m[i] = q_m[i-1] XOR VD[i] for i=1..7, or XNOR when use_xnor.
  - q_m[8] = ~use_xnor.
- Stage 2, DC balance:
  - n1q = ones in q_m[7:0]; n0q = 8 - n1q.
  - cnt is a 5-bit signed register holding running (ones - zeros). It stays within -16..+15 for all legal input sequences.
  - Case A, cnt==0 or n1q==n0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0q-n1q).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1q-n0q) - 2*(~q_m[8]).
- Control period (VDE=0):
  - TMDS <= code[CD]: 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - cnt <= 0.
- Video period (VDE=1): TMDS <= out; cnt <= updated cnt.
- VDE toggling mid-stream:
  - Each cycle is independent except for cnt.
  - The first video symbol after any control cycle always starts with cnt=0.
- Reset asserted mid-stream: TMDS and cnt are forced to their reset values immediately, without waiting for a clock edge.
- No X propagation: every output bit is defined for all input combinations.

Test Plan:
- Reset: hold rst_n=0 with random VD/CD/VDE -> TMDS=10'b1101010100 throughout. Release, drive VDE=0, CD=00 -> TMDS remains 1101010100.
- Control codes: VDE=0, apply CD=01, 10, 11 on successive edges -> TMDS one cycle later = 0010101011, 0101010100, 1010101011.
- Zero bytes from cnt=0: VDE=1, VD=0x00 on two cycles:
  - first symbol 10'b0100000000, cnt=-8;
  - second symbol 10'b1111111111, cnt=+2.
- All-ones byte from cnt=0: VDE=1, VD=0xFF -> TMDS=10'b1000000000 (XNOR path, q_m[8]=0), cnt=-8.
- Counter clearing: after VD=0xFF with cnt=-8, drive one VDE=0 cycle, then VDE=1, VD=0x00 -> TMDS=0100000000 (cnt restarted at 0). Assert rst_n=0 between clock edges -> TMDS=1101010100 immediately.
- Random soak of 10k cycles with random VD/VDE/CD, compared against a reference model:
  - TMDS matches the model every cycle with 1-cycle latency;
  - decoding each video symbol returns the original VD;
  - cumulative ones-minus-zeros over each video run stays within ±16.
